playfield_grid: RTL and testbench
=================================

Name: playfield_grid

Overview:
- Parametrised Tetris playfield: a ROWS x COLS array of CELL_W-bit cells (0 = empty, non-zero = block colour).
- The piece-lock logic writes cells. The renderer reads cells through a registered read port.
- A clear engine scans for full rows, removes each one, and shifts everything above it down by one row. It handles any number of full rows, including non-adjacent ones.
- It reports the lines cleared per operation and keeps a running total for scoring.

Parameters:
- COLS, 10, playfield width in cells
- ROWS, 20, playfield height in cells; row 0 is the top
- CELL_W, 3, bits per cell (colour code)
- TOTAL_W, 16, width of the accumulated-lines counter
- RW = $clog2(ROWS), CW = $clog2(COLS), LW = $clog2(ROWS+1) (derived localparams)

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_row  in  RW  read row address
- rd_col  in  CW  read column address
- rd_data  out  CELL_W  cell contents, registered, 1-cycle latency
- wr_en  in  1  cell write strobe
- wr_row  in  RW  write row address
- wr_col  in  CW  write column address
- wr_data  in  CELL_W  cell value to store
- wr_drop  out  1  1-cycle pulse: a write was rejected (busy or out of range)
- clear_start  in  1  1-cycle request to run a clear pass
- clear_all  in  1  wipe the whole playfield (new game)
- busy  out  1  clear engine active
- done  out  1  1-cycle pulse at the end of a clear pass
- lines_cleared  out  LW  rows removed by the last pass; held until the next pass starts
- total_lines  out  TOTAL_W  accumulated rows removed; saturates at all-ones

Behaviour:
- Reset (sync, any state, including mid-pass):
  - All cells are 0 and the FSM is IDLE.
  - rd_data, wr_drop, busy, done, lines_cleared and total_lines are all 0.
- Read: rd_data <= cell[rd_row][rd_col] on every edge, busy or not. It reflects the array contents before that edge's update. An out-of-range address (rd_row >= ROWS or rd_col >= COLS) returns 0.
- Write:
  - Accepted only in IDLE with an in-range address. The cell takes wr_data at the edge.
  - Otherwise the write is ignored and wr_drop pulses the next cycle.
  - Writing 0 erases a cell.
- Row full: all COLS cells of the row are non-zero.
- FSM states: IDLE, SCAN, SHIFT, DONE. busy = (state != IDLE).
- IDLE:
  - clear_all=1: all cells become 0 in one cycle; clear_start is ignored that cycle; total_lines is unchanged.
  - Else clear_start=1: go to SCAN with scan_row=ROWS-1 and lines_cleared<=0.
  - A write in the same cycle as clear_start is committed first, so the scan sees it.
- SCAN (one row evaluated per cycle):
  - scan_row full -> go to SHIFT.
  - Not full and scan_row>0 -> scan_row-1.
  - Not full and scan_row==0 -> go to DONE.
- SHIFT (1 cycle):
  - Rows 1..scan_row take the contents of the row above; row 0 is zeroed; rows below scan_row are unchanged.
  - lines_cleared+1. total_lines+1, saturating.
  - Return to SCAN with the same scan_row, so the row that drops in is re-checked.
- DONE: done=1 for one cycle, then IDLE.
- Latency with k full rows: done is high in cycle ROWS+2k+1 after the edge that samples clear_start. busy is high in cycles 1..ROWS+2k+1.
- While busy, clear_start and clear_all are ignored, and wr_en is dropped (wr_drop pulses).
- Storage is plain registers; no RAM inference is required.

Test Plan (ROWS=10, COLS=10, CELL_W=3 unless noted):
- Reset:
  - Stimulus: fill cells with non-zero values, assert rst for 1 cycle.
  - Required response: every read returns 0; busy=0, lines_cleared=0, total_lines=0.
- Single clear:
  - Stimulus: write 3'b001 to all of row 9; write 3'b101 to cell[8][2]; pulse clear_start.
  - Required response: done in cycle 13; lines_cleared=1; row 9 is all 0 except col 2 = 3'b101; row 8 is all 0.
- Multi / non-adjacent clear:
  - Stimulus: rows 9, 8 and 6 full; cell[7][0]=3'b010; pulse clear_start.
  - Required response: lines_cleared=3; total_lines=3; cell[9][0]=3'b010; rows 0-8 all 0; done in cycle 17.
- Busy protection:
  - Stimulus: wr_en to cell[0][0] and clear_all on the cycle after clear_start.
  - Required response: wr_drop pulses; cell[0][0] stays 0; the grid is not wiped.
- Same-cycle write and start:
  - Stimulus: row 9 has 9 cells filled; write the 10th cell in the same cycle as clear_start.
  - Required response: lines_cleared=1.
- Mid-pass reset and saturation:
  - Stimulus 1: rst during SHIFT.
    - Required response: next cycle busy=0 and the grid is all 0.
  - Stimulus 2: TOTAL_W=2, four single-row clears.
    - Required response: total_lines stays at 3.

Source files
------------

// File: rtl/playfield_grid.sv
// Tetris playfield: ROWS x COLS cell array with a registered read port, a write port
// and a clear engine that removes full rows and drops everything above them.
module playfield_grid #(
    parameter int unsigned COLS    = 10,
    parameter int unsigned ROWS    = 20,
    parameter int unsigned CELL_W  = 3,
    parameter int unsigned TOTAL_W = 16,
    localparam int unsigned RW     = $clog2(ROWS),
    localparam int unsigned CW     = $clog2(COLS),
    localparam int unsigned LW     = $clog2(ROWS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RW-1:0]      rd_row,
    input  logic [CW-1:0]      rd_col,
    output logic [CELL_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [RW-1:0]      wr_row,
    input  logic [CW-1:0]      wr_col,
    input  logic [CELL_W-1:0]  wr_data,
    output logic               wr_drop,
    input  logic               clear_start,
    input  logic               clear_all,
    output logic               busy,
    output logic               done,
    output logic [LW-1:0]      lines_cleared,
    output logic [TOTAL_W-1:0] total_lines
);

    typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

    state_e state_q, state_d;

    logic [CELL_W-1:0]  cells_q [ROWS][COLS];
    logic [RW-1:0]      scan_row_q;
    logic [LW-1:0]      lines_q;
    logic [TOTAL_W-1:0] total_q;
    logic [CELL_W-1:0]  rd_data_q, rd_next;
    logic               wr_drop_q;

    logic rd_valid, wr_valid, wr_ok, row_full, start_go, wipe;

    assign rd_valid = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
    assign wr_valid = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign wr_ok    = wr_en && (state_q == StIdle) && wr_valid;
    assign wipe     = (state_q == StIdle) && clear_all;
    assign start_go = (state_q == StIdle) && !clear_all && clear_start;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cells_q[scan_row_q][c] == '0) row_full = 1'b0;
        end
    end

    always_comb begin
        rd_next = '0;
        if (rd_valid) rd_next = cells_q[rd_row][rd_col];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_go) state_d = StScan;
            StScan: begin
                if (row_full)                 state_d = StShift;
                else if (scan_row_q == '0)    state_d = StDone;
            end
            StShift: state_d = StScan;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Shift keeps scan_row so the row that drops into it gets re-checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_row_q <= '0;
            lines_q    <= '0;
            total_q    <= '0;
            rd_data_q  <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_next;
            wr_drop_q <= wr_en && !wr_ok && !wipe;
            if (start_go) begin
                scan_row_q <= RW'(ROWS - 1);
                lines_q    <= '0;
            end else if (state_q == StScan && !row_full && scan_row_q != '0) begin
                scan_row_q <= scan_row_q - 1'b1;
            end
            if (state_q == StShift) begin
                lines_q <= lines_q + 1'b1;
                if (total_q != '1) total_q <= total_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || wipe) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) cells_q[r][c] <= '0;
            end
        end else if (state_q == StShift) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r == 0)                       cells_q[r][c] <= '0;
                    else if (r <= int'(scan_row_q))   cells_q[r][c] <= cells_q[r-1][c];
                end
            end
        end else if (wr_ok) begin
            cells_q[wr_row][wr_col] <= wr_data;
        end
    end

    assign rd_data       = rd_data_q;
    assign wr_drop       = wr_drop_q;
    assign lines_cleared = lines_q;
    assign total_lines   = total_q;

endmodule

// File: tb/tb_playfield_grid.sv
// Directed bench for playfield_grid (10x10, 3-bit cells); a second instance with a
// 2-bit total counter shares all inputs to check saturation.
module tb_playfield_grid;

    localparam int R = 10;
    localparam int C = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rd_row = '0, rd_col = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_row = '0, wr_col = '0;
    logic [2:0]  wr_data = '0;
    logic        clear_start = 1'b0, clear_all = 1'b0;

    logic [2:0]  rd_data, rd_data2;
    logic        wr_drop, wr_drop2, busy, busy2, done, done2;
    logic [3:0]  lines_cleared, lines2;
    logic [15:0] total_lines;
    logic [1:0]  total2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [2:0] exp_grid [R][C];

    always #5 clk = ~clk;

    playfield_grid #(.COLS(10), .ROWS(10), .CELL_W(3), .TOTAL_W(16)) dut (
        .clk(clk), .rst(rst), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wr_drop(wr_drop), .clear_start(clear_start), .clear_all(clear_all),
        .busy(busy), .done(done), .lines_cleared(lines_cleared), .total_lines(total_lines)
    );

    playfield_grid #(.COLS(10), .ROWS(10), .CELL_W(3), .TOTAL_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data2),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .wr_drop(wr_drop2), .clear_start(clear_start), .clear_all(clear_all),
        .busy(busy2), .done(done2), .lines_cleared(lines2), .total_lines(total2)
    );

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic [2:0] data;
        logic       exp_drop;
        logic [2:0] exp_rd;
    } wvec_t;

    wvec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_write(input int r, input int c, input int d);
        wr_en = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_data = 3'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_cell(input int r, input int c, output logic [2:0] v);
        rd_row = 4'(r); rd_col = 4'(c);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic fill_row(input int r, input int d);
        for (int c = 0; c < C; c++) do_write(r, c, d);
    endtask

    task automatic zero_exp();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) exp_grid[r][c] = '0;
    endtask

    task automatic check_grid(input string name);
        int bad = 0;
        int fr = -1, fc = -1;
        logic [2:0] v;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                read_cell(r, c, v);
                if (v !== exp_grid[r][c]) begin
                    if (bad == 0) begin fr = r; fc = c; end
                    bad++;
                end
            end
        end
        chk($sformatf("%s cell mismatches (first r%0d c%0d)", name, fr, fc), bad, 0);
    endtask

    task automatic pulse_clear_all();
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
    endtask

    task automatic start_clear();
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [2:0] v;

        vecs[0] = '{4'd0,  4'd0,  3'd5, 1'b0, 3'd5};
        vecs[1] = '{4'd3,  4'd7,  3'd2, 1'b0, 3'd2};
        vecs[2] = '{4'd9,  4'd9,  3'd7, 1'b0, 3'd7};
        vecs[3] = '{4'd12, 4'd0,  3'd3, 1'b1, 3'd0};
        vecs[4] = '{4'd0,  4'd11, 3'd4, 1'b1, 3'd0};
        vecs[5] = '{4'd15, 4'd15, 3'd1, 1'b1, 3'd0};
        vecs[6] = '{4'd3,  4'd7,  3'd0, 1'b0, 3'd0};
        vecs[7] = '{4'd5,  4'd5,  3'd6, 1'b0, 3'd6};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset lines", lines_cleared, 0);
        chk("reset total", total_lines, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset wr_drop", wr_drop, 0);

        // Write/read vectors, including out-of-range addresses and an erase.
        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].row, vecs[i].col, vecs[i].data);
            chk($sformatf("vec%0d wr_drop", i), wr_drop, vecs[i].exp_drop);
            read_cell(vecs[i].row, vecs[i].col, v);
            chk($sformatf("vec%0d rd_data", i), v, vecs[i].exp_rd);
        end

        pulse_clear_all();
        zero_exp();
        check_grid("clear_all");

        // Single clear.
        fill_row(9, 1);
        do_write(8, 2, 5);
        start_clear();
        chk("single busy c1", busy, 1);
        wait_done(1, cyc);
        chk("single done cycle", cyc, 13);
        chk("single lines", lines_cleared, 1);
        chk("single total", total_lines, 1);
        @(negedge clk);
        chk("single done pulse width", done, 0);
        chk("single busy after", busy, 0);
        zero_exp();
        exp_grid[9][2] = 3'd5;
        check_grid("single");

        pulse_clear_all();
        chk("clear_all keeps total", total_lines, 1);
        chk("clear_all keeps lines", lines_cleared, 1);

        // Reset with a populated grid and a non-zero read pending.
        do_write(4, 4, 3);
        read_cell(4, 4, v);
        chk("pre-reset read", v, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst rd_data", rd_data, 0);
        chk("rst lines", lines_cleared, 0);
        chk("rst total", total_lines, 0);
        chk("rst busy", busy, 0);
        zero_exp();
        check_grid("rst");

        // Multi / non-adjacent clear.
        fill_row(9, 3);
        fill_row(8, 3);
        fill_row(6, 3);
        do_write(7, 0, 2);
        start_clear();
        wait_done(1, cyc);
        chk("multi done cycle", cyc, 17);
        chk("multi lines", lines_cleared, 3);
        chk("multi total", total_lines, 3);
        @(negedge clk);
        zero_exp();
        exp_grid[9][0] = 3'd2;
        check_grid("multi");

        // Busy protection: write and clear_all one cycle after start.
        start_clear();
        wr_en = 1'b1; wr_row = 4'd0; wr_col = 4'd0; wr_data = 3'd7;
        clear_all = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; clear_all = 1'b0;
        chk("busy wr_drop", wr_drop, 1);
        wait_done(2, cyc);
        chk("busy done cycle", cyc, 11);
        chk("busy lines", lines_cleared, 0);
        chk("busy total", total_lines, 3);
        @(negedge clk);
        check_grid("busy protect");

        // Same-cycle write and start.
        pulse_clear_all();
        for (int c = 0; c < 9; c++) do_write(9, c, 4);
        wr_en = 1'b1; wr_row = 4'd9; wr_col = 4'd9; wr_data = 3'd1;
        start_clear();
        wr_en = 1'b0;
        wait_done(1, cyc);
        chk("same-cycle done cycle", cyc, 13);
        chk("same-cycle lines", lines_cleared, 1);
        chk("same-cycle total", total_lines, 4);
        @(negedge clk);
        zero_exp();
        check_grid("same-cycle");

        // Reset during SHIFT (cycle 2: row 9 found full in cycle 1).
        fill_row(9, 6);
        do_write(3, 3, 1);
        start_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midpass busy", busy, 0);
        chk("midpass done", done, 0);
        chk("midpass lines", lines_cleared, 0);
        chk("midpass total", total_lines, 0);
        check_grid("midpass");

        // Saturation on the 2-bit counter.
        for (int n = 1; n <= 4; n++) begin
            fill_row(9, 2);
            start_clear();
            wait_done(1, cyc);
            chk($sformatf("sat%0d done cycle", n), cyc, 13);
            chk($sformatf("sat%0d total16", n), total_lines, n);
            chk($sformatf("sat%0d total2", n), total2, (n > 3) ? 3 : n);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
